// File: rtl/dbg_frame_uart_if.sv
// Signal bundle between the debug-bus source and the telemetry UART framer.
// The master drives the snapshot request and debug buses; the slave owns the serial output and status.
interface dbg_frame_uart_if;
  logic       snap_req;
  logic [6:0] dbg_cortisol;
  logic [6:0] dbg_dopamine;
  logic [6:0] dbg_gaba;
  logic [6:0] dbg_norepinephrine;
  logic [6:0] dbg_serotonin;
  logic [15:0] dbg_stimuli;
  logic [9:0] dbg_neurotransmitter_level;
  logic [7:0] dbg_emotional_state;
  logic [7:0] dbg_action;
  logic [1:0] dbg_heartbeat;
  logic [7:0] dbg_nourishment;
  logic [7:0] dbg_vital_energy;
  logic [8:0] dbg_illness;
  logic       tx;
  logic       busy;
  logic       frame_done;
  logic [7:0] overrun_cnt;

  modport master (
    output snap_req, dbg_cortisol, dbg_dopamine, dbg_gaba, dbg_norepinephrine,
           dbg_serotonin, dbg_stimuli, dbg_neurotransmitter_level, dbg_emotional_state,
           dbg_action, dbg_heartbeat, dbg_nourishment, dbg_vital_energy, dbg_illness,
    input  tx, busy, frame_done, overrun_cnt
  );

  modport slave (
    input  snap_req, dbg_cortisol, dbg_dopamine, dbg_gaba, dbg_norepinephrine,
           dbg_serotonin, dbg_stimuli, dbg_neurotransmitter_level, dbg_emotional_state,
           dbg_action, dbg_heartbeat, dbg_nourishment, dbg_vital_energy, dbg_illness,
    output tx, busy, frame_done, overrun_cnt
  );
endinterface

// File: rtl/dbg_frame_uart.sv
// Snapshots the creature's debug buses on request and streams an 18-byte frame
// (sync A5, 16 payload bytes, mod-256 payload checksum) over an 8N1 UART line.
module dbg_frame_uart #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic           clk,
  input  logic           rst_n,
  dbg_frame_uart_if.slave bus
);
  localparam int              CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]   CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [7:0]      SYNC_BYTE = 8'hA5;
  localparam logic [4:0]      LAST_BYTE = 5'd17;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [4:0]    byte_idx_q, byte_idx_d;
  logic          tx_q, tx_d;
  logic          done_q, done_d;
  logic [7:0]    ovr_q, ovr_d;
  logic [7:0]    snap_q [16];
  logic [7:0]    csum_q;
  logic [7:0]    payload [16];
  logic [7:0]    csum_in;
  logic [7:0]    cur_byte;
  logic          accept;
  logic          bit_end;

  always_comb begin
    payload[0]  = {1'b0, bus.dbg_cortisol};
    payload[1]  = {1'b0, bus.dbg_dopamine};
    payload[2]  = {1'b0, bus.dbg_gaba};
    payload[3]  = {1'b0, bus.dbg_norepinephrine};
    payload[4]  = {1'b0, bus.dbg_serotonin};
    payload[5]  = bus.dbg_stimuli[15:8];
    payload[6]  = bus.dbg_stimuli[7:0];
    payload[7]  = {6'b0, bus.dbg_neurotransmitter_level[9:8]};
    payload[8]  = bus.dbg_neurotransmitter_level[7:0];
    payload[9]  = bus.dbg_emotional_state;
    payload[10] = bus.dbg_action;
    payload[11] = {6'b0, bus.dbg_heartbeat};
    payload[12] = bus.dbg_nourishment;
    payload[13] = bus.dbg_vital_energy;
    payload[14] = {7'b0, bus.dbg_illness[8]};
    payload[15] = bus.dbg_illness[7:0];
  end

  // Checksum is formed from the live inputs so it is latched alongside the snapshot.
  always_comb begin
    csum_in = '0;
    for (int i = 0; i < 16; i++) csum_in = csum_in + payload[i];
  end

  assign accept  = (state_q == IDLE) && bus.snap_req;
  assign bit_end = (clk_cnt_q == CNT_LAST);

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_snap
      always_ff @(posedge clk) begin
        if (rst_n && accept) snap_q[gi] <= payload[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst_n && accept) csum_q <= csum_in;
  end

  // Byte 0 is sync, 1..16 map onto snapshot entries 0..15 (4-bit wrap covers 16), 17 is the checksum.
  always_comb begin
    cur_byte = SYNC_BYTE;
    if (byte_idx_q == LAST_BYTE) cur_byte = csum_q;
    else if (byte_idx_q != 5'd0) cur_byte = snap_q[byte_idx_q[3:0] - 4'd1];
  end

  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = bit_end ? '0 : clk_cnt_q + CW'(1);
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
    ovr_d      = ovr_q;
    if (bus.snap_req && (state_q != IDLE) && (ovr_q != 8'hFF)) ovr_d = ovr_q + 8'd1;
    case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        tx_d      = 1'b1;
        if (bus.snap_req) begin
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
          tx_d      = cur_byte[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = cur_byte[bit_idx_d];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (byte_idx_q == LAST_BYTE) begin
            state_d    = IDLE;
            byte_idx_d = 5'd0;
            done_d     = 1'b1;
            tx_d       = 1'b1;
          end else begin
            state_d    = START;
            byte_idx_d = byte_idx_q + 5'd1;
            tx_d       = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      clk_cnt_q  <= '0;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= 5'd0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
      ovr_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
      ovr_q      <= ovr_d;
    end
  end

  assign bus.tx          = tx_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.frame_done  = done_q;
  assign bus.overrun_cnt = ovr_q;
endmodule
